// File: rtl/aoi21_scan_bank_pkg.sv
// Shared encodings, limits and the per-channel gate function for the aoi21_scan_bank family.
package aoi21_scan_bank_pkg;

  localparam int MODE_AOI21 = 0;
  localparam int MODE_OAI21 = 1;
  localparam int CH_MAX     = 64;

  // Single definition of the compound gate, reused by the slices and the parity predictor.
  function automatic logic gateEval(input int mode, input logic a, input logic b1, input logic b2);
    if (mode == MODE_OAI21) return ~(a & (b1 | b2));
    return ~(a | (b1 & b2));
  endfunction

endpackage

// File: rtl/aoi21_scan_bank_sdff.sv
// One scan slice: AOI21/OAI21 gate, shift/capture/hold mux and a synchronously reset flop.
module aoi21_sdff
  import aoi21_scan_bank_pkg::*;
#(
  parameter int MODE = MODE_AOI21
) (
  input  logic clk,
  input  logic rstN,
  input  logic en,
  input  logic scanEn,
  input  logic scanIn,
  input  logic a,
  input  logic b1,
  input  logic b2,
  output logic q
);

  logic y;

  assign y = gateEval(MODE, a, b1, b2);

  // NOTE: reset is sampled on the clock edge (synchronous), so it sits inside the
  // posedge-only sensitivity list; state is updated with <= so all slices see the
  // pre-edge value of their neighbour when shifting.
  always_ff @(posedge clk) begin
    if (!rstN)       q <= 1'b0;
    else if (scanEn) q <= scanIn;
    else if (en)     q <= y;
  end

endmodule

// File: rtl/aoi21_scan_bank.sv
// Registered, scannable bank of CH AOI21/OAI21 channels.
// Optional parity stage enabled by defining AOI21_SCAN_BANK_PARITY_EN.
module aoi21_scan_bank
  import aoi21_scan_bank_pkg::*;
#(
  parameter int CH   = 8,
  parameter int MODE = MODE_AOI21
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          EN,
  input  logic          SE,
  input  logic          SI,
  input  logic [CH-1:0] A,
  input  logic [CH-1:0] B1,
  input  logic [CH-1:0] B2,
  output logic [CH-1:0] Q,
  output logic          SO
`ifdef AOI21_SCAN_BANK_PARITY_EN
  ,
  output logic          PAR
`endif
);

  if (CH < 1 || CH > CH_MAX) begin : gChRangeCheck
    $error("aoi21_scan_bank: CH=%0d outside 1..%0d", CH, CH_MAX);
  end
  if (MODE != MODE_AOI21 && MODE != MODE_OAI21) begin : gModeCheck
    $error("aoi21_scan_bank: MODE=%0d is not a supported gate function", MODE);
  end

  // Slice 0 takes SI; every other slice takes its lower neighbour, forming the chain.
  for (genvar i = 0; i < CH; i++) begin : gSlice
    logic chainIn;
    if (i == 0) begin : gHead
      assign chainIn = SI;
    end else begin : gBody
      assign chainIn = Q[i-1];
    end

    aoi21_sdff #(.MODE(MODE)) uSlice (
      .clk   (CLK),
      .rstN  (RSTN),
      .en    (EN),
      .scanEn(SE),
      .scanIn(chainIn),
      .a     (A[i]),
      .b1    (B1[i]),
      .b2    (B2[i]),
      .q     (Q[i])
    );
  end

`ifdef AOI21_SCAN_BANK_PARITY_EN
  logic parNext;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    parNext = 1'b0;
    for (int i = 0; i < CH; i++) parNext ^= gateEval(MODE, A[i], B1[i], B2[i]);
  end

  // Parity flop doubles as the last scan stage behind Q[CH-1].
  always_ff @(posedge CLK) begin
    if (!RSTN)    PAR <= 1'b0;
    else if (SE)  PAR <= Q[CH-1];
    else if (EN)  PAR <= parNext;
  end

  assign SO = PAR;
`else
  assign SO = Q[CH-1];
`endif

endmodule

// File: tb/tb_aoi21_scan_bank.sv
// Self-checking bench for aoi21_scan_bank: AOI21 and OAI21 instances side by side, table vectors,
// scan/reset sequences and a randomized run against a shift-register reference model.
module tb_aoi21_scan_bank;

  localparam int CH = 8;
`ifdef AOI21_SCAN_BANK_PARITY_EN
  localparam int L = CH + 1;
  localparam bit HAS_PAR = 1'b1;
`else
  localparam int L = CH;
  localparam bit HAS_PAR = 1'b0;
`endif

  logic          CLK;
  logic          RSTN, EN, SE, SI;
  logic [CH-1:0] A, B1, B2;
  logic [CH-1:0] qAoi, qOai;
  logic          soAoi, soOai;
`ifdef AOI21_SCAN_BANK_PARITY_EN
  logic          parAoi, parOai;
`endif

  int errors = 0;
  int checks = 0;

  aoi21_scan_bank #(.CH(CH), .MODE(0)) dutAoi (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .SE(SE), .SI(SI),
    .A(A), .B1(B1), .B2(B2), .Q(qAoi), .SO(soAoi)
`ifdef AOI21_SCAN_BANK_PARITY_EN
    , .PAR(parAoi)
`endif
  );

  aoi21_scan_bank #(.CH(CH), .MODE(1)) dutOai (
    .CLK(CLK), .RSTN(RSTN), .EN(EN), .SE(SE), .SI(SI),
    .A(A), .B1(B1), .B2(B2), .Q(qOai), .SO(soOai)
`ifdef AOI21_SCAN_BANK_PARITY_EN
    , .PAR(parOai)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rstn, input logic en, input logic se, input logic si,
                       input logic [CH-1:0] a, input logic [CH-1:0] b1, input logic [CH-1:0] b2);
    RSTN = rstn; EN = en; SE = se; SI = si; A = a; B1 = b1; B2 = b2;
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic          en, se, si;
    logic [CH-1:0] a, b1, b2;
    logic [CH-1:0] expAoi, expOai;
    logic          expPar;
  } vec_t;

  vec_t vecs[12];

  // Reference model: each bank is an L-bit shift register value {par, q} (par only with parity).
  logic [CH-1:0] mqAoi, mqOai;
  logic          mpAoi, mpOai;

  task automatic modelStep(input logic rstn, input logic en, input logic se, input logic si,
                           input logic [CH-1:0] a, input logic [CH-1:0] b1, input logic [CH-1:0] b2);
    if (!rstn) begin
      mqAoi = '0; mqOai = '0; mpAoi = 1'b0; mpOai = 1'b0;
    end else if (se) begin
      mpAoi = mqAoi[CH-1];
      mpOai = mqOai[CH-1];
      mqAoi = {mqAoi[CH-2:0], si};
      mqOai = {mqOai[CH-2:0], si};
    end else if (en) begin
      mqAoi = ~(a | (b1 & b2));
      mqOai = ~(a & (b1 | b2));
      mpAoi = ^mqAoi;
      mpOai = ^mqOai;
    end
  endtask

  initial begin
    logic [CH-1:0] pat;
    logic [CH-1:0] ra, rb1, rb2;
    logic          rr, re, rs, ri;

    drive(1'b0, 1'b1, 1'b1, 1'b1, CH'($urandom), CH'($urandom), CH'($urandom));

    // Reset dominates EN and SE, held for two cycles with random data.
    for (int c = 0; c < 2; c++) begin
      step();
      check("reset_q_aoi", 64'(qAoi), 64'h00);
      check("reset_q_oai", 64'(qOai), 64'h00);
      check("reset_so", 64'(soAoi), 64'h0);
`ifdef AOI21_SCAN_BANK_PARITY_EN
      check("reset_par", 64'(parAoi), 64'h0);
`endif
      drive(1'b0, 1'b1, 1'b1, 1'b0, CH'($urandom), CH'($urandom), CH'($urandom));
    end

    // Capture, hold, second capture, then eight shifts with EN also high.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h0F, 8'hF0, 8'h30, 8'hC0, 8'hFF, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'hC0, 8'hFF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'hF0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h3E, 8'h01, 8'h00, 8'hC1, 8'hFF, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h83, 8'hFF, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h06, 8'hFE, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h0D, 8'hFD, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h1B, 8'hFB, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h36, 8'hF6, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h6C, 8'hEC, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hD9, 8'hD9, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hB2, 8'hB2, 1'b1};

    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].en, vecs[i].se, vecs[i].si, vecs[i].a, vecs[i].b1, vecs[i].b2);
      step();
      check($sformatf("vec%0d_q_aoi", i), 64'(qAoi), 64'(vecs[i].expAoi));
      check($sformatf("vec%0d_q_oai", i), 64'(qOai), 64'(vecs[i].expOai));
`ifdef AOI21_SCAN_BANK_PARITY_EN
      check($sformatf("vec%0d_par", i), 64'(parAoi), 64'(vecs[i].expPar));
      check($sformatf("vec%0d_so", i), 64'(soAoi), 64'(vecs[i].expPar));
`else
      check($sformatf("vec%0d_so", i), 64'(soAoi), 64'(vecs[i].expAoi[CH-1]));
`endif
    end

    // Scan latency from a clean chain: first bit reaches SO after edge L, not before.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    pat = 8'b0100_1101; // bit k is shifted in at edge k+1
    for (int k = 1; k <= L; k++) begin
      drive(1'b1, 1'b1, 1'b1, (k <= CH) ? pat[k-1] : 1'b0, '1, '0, '0);
      step();
      if (k == L - 1) check("latency_so_early", 64'(soAoi), 64'h0);
      if (k == L)     check("latency_so_first", 64'(soAoi), 64'h1);
      if (k == CH)    check("latency_q_full", 64'(qAoi), 64'hB2);
    end

    // Reset asserted in the fourth shift cycle discards the partial load.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, '0, '0, '0);
      step();
    end
    check("midshift_pre_q", 64'(qAoi), 64'h07);
    drive(1'b0, 1'b1, 1'b1, 1'b1, '0, '0, '0);
    step();
    check("midshift_rst_q", 64'(qAoi), 64'h00);
    check("midshift_rst_so", 64'(soAoi), 64'h0);
    for (int k = 1; k <= CH; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, '0, '0, '0);
      step();
      if (k == 1) check("midshift_first_q", 64'(qOai), 64'h01);
    end
    check("midshift_ones_q", 64'(qAoi), 64'hFF);
    check("midshift_ones_so", 64'(soAoi), HAS_PAR ? 64'h0 : 64'h1);

    // Randomized run, starting from a reset so the model is in step.
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    modelStep(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    for (int n = 0; n < 400; n++) begin
      rr = ($urandom_range(0, 15) != 0);
      re = $urandom_range(0, 1);
      rs = ($urandom_range(0, 3) == 0);
      ri = $urandom_range(0, 1);
      ra = CH'($urandom); rb1 = CH'($urandom); rb2 = CH'($urandom);
      drive(rr, re, rs, ri, ra, rb1, rb2);
      modelStep(rr, re, rs, ri, ra, rb1, rb2);
      step();
      check("rand_q_aoi", 64'(qAoi), 64'(mqAoi));
      check("rand_q_oai", 64'(qOai), 64'(mqOai));
`ifdef AOI21_SCAN_BANK_PARITY_EN
      check("rand_par_aoi", 64'(parAoi), 64'(mpAoi));
      check("rand_par_oai", 64'(parOai), 64'(mpOai));
      check("rand_so_oai", 64'(soOai), 64'(mpOai));
`else
      check("rand_so_oai", 64'(soOai), 64'(mqOai[CH-1]));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
